// File: rtl/box_controller_multi.sv
// Multi-box bounding-box controller: button-driven move/resize of NUM_BOXES
// boxes with press-and-hold auto-repeat and saturating steps.
module box_controller_multi #(
  parameter int IMAGE_WIDTH   = 1280,
  parameter int IMAGE_HEIGHT  = 720,
  parameter int NUM_BOXES     = 4,
  parameter int MIN_BOX_SIZE  = 5,
  parameter int MAX_BOX_SIZE  = 300,
  parameter int INIT_BOX_SIZE = 50,
  parameter int STEP          = 10,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int PERIOD_0      = 1000000,
  parameter int PERIOD_1      = 5000000,
  parameter int PERIOD_2      = 10000000,
  parameter int PERIOD_3      = 20000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [1:0]             speed_sel,
  input  logic [2:0]             box_sel,
  input  logic [3:0]             butns,
  output logic [15:0]            x1_o,
  output logic [15:0]            x2_o,
  output logic [15:0]            y1_o,
  output logic [15:0]            y2_o,
  output logic [NUM_BOXES*48-1:0] all_boxes_o,
  output logic                   step_o,
  output logic [3:0]             leds
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam logic [12:0] STEP_C = 13'(STEP);
  localparam logic [12:0] IWM1_C = 13'(IMAGE_WIDTH - 1);
  localparam logic [12:0] IHM1_C = 13'(IMAGE_HEIGHT - 1);
  localparam logic [12:0] MAX_C  = 13'(MAX_BOX_SIZE);
  localparam logic [12:0] MIN_C  = 13'(MIN_BOX_SIZE);
  localparam logic [31:0] RD_M1  = 32'(REPEAT_DELAY - 1);
  localparam logic [3:0]  NUM_C  = 4'(NUM_BOXES);

  function automatic logic [12:0] min13(input logic [12:0] a, input logic [12:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [47:0] init_box(input int i);
    logic [11:0] x1;
    x1 = 12'(i * INIT_BOX_SIZE);
    return {12'(INIT_BOX_SIZE - 1), 12'd0, x1 + 12'(INIT_BOX_SIZE - 1), x1};
  endfunction

  // Box packing is {y2,y1,x2,x1}; every distance is clamped so no edge leaves its legal range.
  function automatic logic [47:0] step_box(input logic [47:0] b, input logic [1:0] m,
                                           input logic [3:0] bt);
    logic [12:0] x1, x2, y1, y2, w, h, da, db;
    x1 = {1'b0, b[11:0]};
    x2 = {1'b0, b[23:12]};
    y1 = {1'b0, b[35:24]};
    y2 = {1'b0, b[47:36]};
    w  = x2 - x1 + 13'd1;
    h  = y2 - y1 + 13'd1;
    case (m)
      2'b00: begin
        da = (bt[0] && !bt[1]) ? min13(STEP_C, x1) : 13'd0;
        db = (bt[1] && !bt[0]) ? min13(STEP_C, IWM1_C - x2) : 13'd0;
        x1 = x1 - da + db;
        x2 = x2 - da + db;
        da = (bt[2] && !bt[3]) ? min13(STEP_C, y1) : 13'd0;
        db = (bt[3] && !bt[2]) ? min13(STEP_C, IHM1_C - y2) : 13'd0;
        y1 = y1 - da + db;
        y2 = y2 - da + db;
      end
      2'b01: begin
        da = (bt[2] && !bt[3]) ?
             min13(min13(min13(STEP_C, x1), min13(y1, IWM1_C - x2)),
                   min13(min13(IHM1_C - y2, (MAX_C - w) >> 1), (MAX_C - h) >> 1)) : 13'd0;
        db = (bt[3] && !bt[2]) ?
             min13(STEP_C, min13((w - MIN_C) >> 1, (h - MIN_C) >> 1)) : 13'd0;
        x1 = x1 - da + db;
        y1 = y1 - da + db;
        x2 = x2 + da - db;
        y2 = y2 + da - db;
      end
      2'b10: begin
        da = bt[0] ? min13(STEP_C, min13(x1, MAX_C - w)) : 13'd0;
        x1 = x1 - da;
        w  = w + da;
        db = bt[1] ? min13(STEP_C, min13(IWM1_C - x2, MAX_C - w)) : 13'd0;
        x2 = x2 + db;
        da = bt[2] ? min13(STEP_C, min13(y1, MAX_C - h)) : 13'd0;
        y1 = y1 - da;
        h  = h + da;
        db = bt[3] ? min13(STEP_C, min13(IHM1_C - y2, MAX_C - h)) : 13'd0;
        y2 = y2 + db;
      end
      default: begin
        da = bt[0] ? min13(STEP_C, w - MIN_C) : 13'd0;
        x1 = x1 + da;
        w  = w - da;
        db = bt[1] ? min13(STEP_C, w - MIN_C) : 13'd0;
        x2 = x2 - db;
        da = bt[2] ? min13(STEP_C, h - MIN_C) : 13'd0;
        y1 = y1 + da;
        h  = h - da;
        db = bt[3] ? min13(STEP_C, h - MIN_C) : 13'd0;
        y2 = y2 - db;
      end
    endcase
    return {y2[11:0], y1[11:0], x2[11:0], x1[11:0]};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, period_s;
  logic [2:0]  act_q, act_d, bsel_q;
  logic [1:0]  mode_q;
  logic        step_q, step_d, apply_s;
  logic [3:0]  leds_q;
  logic [47:0] box_q [NUM_BOXES];
  logic [47:0] box_d [NUM_BOXES];
  logic [47:0] cur_s, new_s;

  always_comb begin
    case (speed_sel)
      2'd0:    period_s = 32'(PERIOD_0);
      2'd1:    period_s = 32'(PERIOD_1);
      2'd2:    period_s = 32'(PERIOD_2);
      default: period_s = 32'(PERIOD_3);
    endcase
  end

  // Release, a mode change or a box change abandons the hold without stepping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    apply_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (butns != 4'd0) begin
          apply_s = 1'b1;
          state_d = HOLD;
          cnt_d   = RD_M1;
        end else begin
          cnt_d   = 32'd0;
        end
      end
      HOLD, REPEAT: begin
        if (butns == 4'd0 || mode != mode_q || box_sel != bsel_q) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
        end else if (cnt_q == 32'd0) begin
          apply_s = 1'b1;
          state_d = REPEAT;
          cnt_d   = period_s - 32'd1;
        end else begin
          cnt_d   = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  always_comb begin
    cur_s = box_q[0];
    for (int i = 0; i < NUM_BOXES; i++) begin
      cur_s = (act_q == 3'(i)) ? box_q[i] : cur_s;
    end
    new_s  = step_box(cur_s, mode, butns);
    step_d = apply_s && (new_s != cur_s);
    act_d  = (state_q == IDLE && {1'b0, box_sel} < NUM_C) ? box_sel : act_q;
    for (int i = 0; i < NUM_BOXES; i++) begin
      box_d[i] = (apply_s && act_q == 3'(i)) ? new_s : box_q[i];
      all_boxes_o[i*48 +: 48] = box_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      act_q   <= 3'd0;
      bsel_q  <= 3'd0;
      mode_q  <= 2'd0;
      step_q  <= 1'b0;
      leds_q  <= 4'b0001;
      for (int i = 0; i < NUM_BOXES; i++) box_q[i] <= init_box(i);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      bsel_q  <= box_sel;
      mode_q  <= mode;
      step_q  <= step_d;
      leds_q  <= 4'b0001 << mode;
      for (int i = 0; i < NUM_BOXES; i++) box_q[i] <= box_d[i];
    end
  end

  assign x1_o   = {4'd0, cur_s[11:0]};
  assign x2_o   = {4'd0, cur_s[23:12]};
  assign y1_o   = {4'd0, cur_s[35:24]};
  assign y2_o   = {4'd0, cur_s[47:36]};
  assign step_o = step_q;
  assign leds   = leds_q;

endmodule
